// File: rtl/tetris_pkg.sv
// Shared types and helpers for the Tetris line-clear stage: FSM states, board geometry, scoring.
package tetris_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 4;
  localparam int BOARD_W  = 32;

  localparam logic [3:0] FULL_ROW = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Points awarded for the number of rows removed in one pass.
  function automatic logic [3:0] pts(input logic [3:0] n);
    logic [3:0] p;
    case (n)
      4'd0:    p = 4'd0;
      4'd1:    p = 4'd1;
      4'd2:    p = 4'd3;
      4'd3:    p = 4'd5;
      default: p = 4'd8;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/row_shifter.sv
// Combinational row removal: drops row i_idx, moves every higher row down one, zero-fills the top.
module row_shifter
  import tetris_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic [ROWS*COLS-1:0]     i_board,
  input  logic [$clog2(ROWS)-1:0]  i_idx,
  output logic [ROWS*COLS-1:0]     o_board
);

  always_comb begin
    o_board = i_board;
    for (int r = 0; r < ROWS; r++) begin
      if (r >= int'(i_idx)) begin
        if (r == ROWS - 1) begin
          o_board[r*COLS +: COLS] = '0;
        end else begin
          o_board[r*COLS +: COLS] = i_board[(r+1)*COLS +: COLS];
        end
      end
    end
  end

endmodule

// File: rtl/line_clear.sv
// Line-clear stage: scans the landed board one row per cycle, removes full rows, updates score.
// Optional level tracking is built when LINE_CLEAR_LEVEL_EN is defined.
module line_clear
  import tetris_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int SCORE_W = 16
) (
  input  logic               clka,
  input  logic               restart,
  input  logic               touched,
  input  logic [31:0]        board_in,
  output logic [31:0]        board_out,
  output logic               done,
  output logic               busy,
  output logic [3:0]         lines_cleared,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic [3:0]         level,
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = $clog2(ROWS);

  // Handshake: touched is a level request, sampled only in IDLE (ignored while busy);
  // done is a one-cycle pulse during which board_out/score/lines_cleared are valid.

  state_t                r_state;
  state_t                w_next;
  logic [31:0]           r_work;
  logic [IDX_W-1:0]      r_idx;
  logic [3:0]            r_cnt;
  logic [31:0]           r_board_out;
  logic [3:0]            r_lines;
  logic [SCORE_W-1:0]    r_score;
  logic                  r_game_over;

  logic [COLS-1:0]       w_row;
  logic                  w_row_full;
  logic                  w_last;
  logic                  w_enter_done;
  logic [31:0]           w_shifted;
  logic [SCORE_W:0]      w_score_sum;
  logic [SCORE_W-1:0]    w_score_next;

  assign w_row        = r_work[int'(r_idx)*COLS +: COLS];
  assign w_row_full   = (w_row == FULL_ROW);
  assign w_last       = (r_idx == IDX_W'(ROWS - 1));
  assign w_enter_done = (r_state == SCAN) && !w_row_full && w_last;

  assign w_score_sum  = {1'b0, r_score} + (SCORE_W+1)'(pts(r_cnt));
  assign w_score_next = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

  row_shifter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_row_shifter (
    .i_board (r_work),
    .i_idx   (r_idx),
    .o_board (w_shifted)
  );

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // The same row is rechecked after a shift, since a full row may have dropped into it.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (touched) w_next = SCAN;
      SCAN: begin
        if (w_row_full)  w_next = SHIFT;
        else if (w_last) w_next = DONE;
      end
      SHIFT:   w_next = SCAN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      r_work      <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_board_out <= '0;
      r_lines     <= '0;
      r_score     <= '0;
      r_game_over <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (touched) begin
            r_work <= board_in;
            r_idx  <= '0;
            r_cnt  <= '0;
          end
        end
        SCAN: begin
          if (!w_row_full && !w_last) begin
            r_idx <= r_idx + 1'b1;
          end
          if (w_enter_done) begin
            r_board_out <= r_work;
            r_lines     <= r_cnt;
            r_score     <= w_score_next;
            if (r_work[(ROWS-1)*COLS +: COLS] != '0) begin
              r_game_over <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_work <= w_shifted;
          if (r_cnt != 4'hF) begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LINE_CLEAR_LEVEL_EN
  logic [7:0] r_total;
  logic [3:0] r_level;
  logic [8:0] w_total_sum;
  logic [7:0] w_total_next;

  assign w_total_sum  = {1'b0, r_total} + 9'(r_cnt);
  assign w_total_next = w_total_sum[8] ? 8'hFF : w_total_sum[7:0];

  // level = total/4 capped at 15; total/4 exceeds 15 exactly when bits [7:6] are set.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      r_total <= '0;
      r_level <= '0;
    end else if (w_enter_done) begin
      r_total <= w_total_next;
      r_level <= (w_total_next[7:6] != 2'b00) ? 4'hF : w_total_next[5:2];
    end
  end

  assign level = r_level;
`else
  assign level = 4'd0;
`endif

  assign board_out     = r_board_out;
  assign lines_cleared = r_lines;
  assign score         = r_score;
  assign game_over     = r_game_over;
  assign done          = (r_state == DONE);
  assign busy          = (r_state != IDLE);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_line_clear.sv
// Self-checking bench for line_clear: scoreboard of expected pass results against a row-compaction model.
module tb_line_clear;

  localparam int EXP_W = 65;

  logic        clka = 1'b0;
  logic        restart;
  logic        touched;
  logic [31:0] board_in;
  logic [31:0] board_out;
  logic        done;
  logic        busy;
  logic [3:0]  lines_cleared;
  logic [15:0] score;
  logic        game_over;
  logic [3:0]  level;
  logic [1:0]  dbg_state;

  logic        touched2;
  logic [31:0] board_in2;
  logic [31:0] board_out2;
  logic        done2;
  logic        busy2;
  logic [3:0]  lines_cleared2;
  logic [3:0]  score2;
  logic        game_over2;
  logic [3:0]  level2;
  logic [1:0]  dbg_state2;

  int total = 0;
  int bad   = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               m_score;
  int               m_total;
  logic             m_go;

  // ---------------- clock / reset ----------------
  always #5 clka = ~clka;

  line_clear dut (
    .clka          (clka),
    .restart       (restart),
    .touched       (touched),
    .board_in      (board_in),
    .board_out     (board_out),
    .done          (done),
    .busy          (busy),
    .lines_cleared (lines_cleared),
    .score         (score),
    .game_over     (game_over),
    .level         (level),
    .dbg_state     (dbg_state)
  );

  line_clear #(.SCORE_W(4)) dut_sat (
    .clka          (clka),
    .restart       (restart),
    .touched       (touched2),
    .board_in      (board_in2),
    .board_out     (board_out2),
    .done          (done2),
    .busy          (busy2),
    .lines_cleared (lines_cleared2),
    .score         (score2),
    .game_over     (game_over2),
    .level         (level2),
    .dbg_state     (dbg_state2)
  );

  // ---------------- model ----------------
  function automatic int m_pts(input int n);
    if (n == 0) return 0;
    if (n == 1) return 1;
    if (n == 2) return 3;
    if (n == 3) return 5;
    return 8;
  endfunction

  function automatic int m_level(input int t);
`ifdef LINE_CLEAR_LEVEL_EN
    return (t / 4 > 15) ? 15 : t / 4;
`else
    return 0 + (t & 0);
`endif
  endfunction

  function automatic void model_compact(input logic [31:0] b, output logic [31:0] o, output int f);
    int k;
    k = 0;
    o = '0;
    f = 0;
    for (int r = 0; r < 8; r++) begin
      if (b[4*r +: 4] == 4'hF) begin
        f++;
      end else begin
        o[4*k +: 4] = b[4*r +: 4];
        k++;
      end
    end
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_total = 0;
    m_go    = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_expected(input logic [31:0] b);
    logic [31:0] o;
    int f, lat, lvl;
    model_compact(b, o, f);
    m_score = m_score + m_pts(f);
    if (m_score > 65535) m_score = 65535;
    m_total = m_total + f;
    if (m_total > 255) m_total = 255;
    if (o[31:28] != 4'h0) m_go = 1'b1;
    lvl = m_level(m_total);
    lat = 8 + 2 * f;
    exp_q.push_back({8'(lat), 4'(lvl), m_go, 16'(m_score), 4'(f), o});
  endtask

  // ---------------- drivers ----------------
  task automatic start_pass(input logic [31:0] b);
    @(negedge clka);
    board_in = b;
    touched  = 1'b1;
    push_expected(b);
    @(posedge clka);
  endtask

  // Called right after E0; touched is dropped once lat reaches hold.
  task automatic wait_done(input int hold);
    int lat;
    logic got;
    logic [EXP_W-1:0] e;
    lat = 0;
    got = 1'b0;
    @(negedge clka);
    if (lat >= hold) touched = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL busy_start: busy=%b done=%b expected busy=1 done=0", busy, done);
    end
    while (lat < 60 && !got) begin
      @(posedge clka);
      lat++;
      @(negedge clka);
      if (lat >= hold) touched = 1'b0;
      total++;
      if (busy !== 1'b1) begin
        bad++;
        $display("FAIL busy_run: busy=%b at cycle %0d expected 1", busy, lat);
      end
      if (done === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: no done within %0d cycles", lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: done seen with no expected entry");
      return;
    end
    e = exp_q.pop_front();
    if (8'(lat) !== e[64:57]) begin
      bad++;
      $display("FAIL latency: got %0d expected %0d", lat, e[64:57]);
    end
    total++;
    if (board_out !== e[31:0]) begin
      bad++;
      $display("FAIL board_out: got %h expected %h", board_out, e[31:0]);
    end
    total++;
    if (lines_cleared !== e[35:32]) begin
      bad++;
      $display("FAIL lines_cleared: got %0d expected %0d", lines_cleared, e[35:32]);
    end
    total++;
    if (score !== e[51:36]) begin
      bad++;
      $display("FAIL score: got %h expected %h", score, e[51:36]);
    end
    total++;
    if (game_over !== e[52]) begin
      bad++;
      $display("FAIL game_over: got %b expected %b", game_over, e[52]);
    end
    total++;
    if (level !== e[56:53]) begin
      bad++;
      $display("FAIL level: got %0d expected %0d", level, e[56:53]);
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clka);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s: busy=%b done=%b expected 0 0", name, busy, done);
    end
  endtask

  task automatic check_cleared(input string name);
    total++;
    if (board_out !== 32'h0 || score !== 16'h0 || lines_cleared !== 4'h0 ||
        game_over !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || level !== 4'h0) begin
      bad++;
      $display("FAIL %s: board=%h score=%h lines=%0d go=%b busy=%b done=%b level=%0d expected all 0",
               name, board_out, score, lines_cleared, game_over, busy, done, level);
    end
  endtask

  task automatic do_reset();
    @(negedge clka);
    restart = 1'b1;
    #1;
    model_reset();
    check_cleared("reset_async");
    @(negedge clka);
    restart = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    restart   = 1'b1;
    touched   = 1'b0;
    board_in  = '0;
    touched2  = 1'b0;
    board_in2 = '0;
    model_reset();
    repeat (2) @(posedge clka);
    @(negedge clka);
    restart = 1'b0;
    check_cleared("reset_state");
    check_idle("reset_idle");
  endtask

  task automatic test_restart_mid();
    start_pass(32'h0000_000F);
    wait_done(0);
    start_pass(32'h0000_00FF);
    @(negedge clka);
    touched = 1'b0;
    repeat (2) @(negedge clka);
    restart = 1'b1;
    #1;
    model_reset();
    check_cleared("restart_mid");
    @(negedge clka);
    restart = 1'b0;
    check_idle("restart_mid_idle");
  endtask

  task automatic test_single_row();
    start_pass(32'h0000_000F);
    wait_done(0);
    check_idle("single_idle");
  endtask

  task automatic test_two_rows();
    start_pass(32'h0000_2FF1);
    wait_done(0);
    check_idle("two_idle");
  endtask

  task automatic test_touched_hold();
    start_pass(32'h0000_0000);
    wait_done(3);
    check_idle("hold_idle");
    check_idle("hold_idle2");
  endtask

  task automatic test_retrigger();
    start_pass(32'h0000_0000);
    wait_done(1000);
    check_idle("retrig_idle");
    push_expected(32'h0000_0000);
    @(posedge clka);
    wait_done(0);
    check_idle("retrig_end");
  endtask

  task automatic test_game_over();
    start_pass(32'h1000_0000);
    wait_done(0);
    start_pass(32'h0000_0000);
    wait_done(0);
    check_idle("go_idle");
    do_reset();
  endtask

  task automatic test_multi();
    logic [31:0] b;
    start_pass(32'hF0F0_F0F0);
    wait_done(0);
    start_pass(32'hFFFF_FFFF);
    wait_done(0);
    start_pass(32'h0000_FFFF);
    wait_done(0);
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 2) == 0) b[4*r +: 4] = 4'hF;
        else b[4*r +: 4] = 4'($urandom_range(0, 14));
      end
      start_pass(b);
      wait_done(0);
    end
    check_idle("multi_idle");
  endtask

  task automatic test_score_sat();
    int exp_s, exp_t, lat;
    logic got;
    do_reset();
    exp_s = 0;
    exp_t = 0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clka);
      board_in2 = 32'h0000_FFFF;
      touched2  = 1'b1;
      exp_s = exp_s + 8;
      if (exp_s > 15) exp_s = 15;
      exp_t = exp_t + 4;
      @(posedge clka);
      @(negedge clka);
      touched2 = 1'b0;
      lat = 0;
      got = 1'b0;
      while (lat < 60 && !got) begin
        @(posedge clka);
        lat++;
        @(negedge clka);
        if (done2 === 1'b1) got = 1'b1;
      end
      total++;
      if (!got || lat != 16) begin
        bad++;
        $display("FAIL sat_latency: got %0d expected 16", lat);
      end
      total++;
      if (score2 !== 4'(exp_s) || board_out2 !== 32'h0 || lines_cleared2 !== 4'd4) begin
        bad++;
        $display("FAIL sat_score: score=%h board=%h lines=%0d expected score=%h board=0 lines=4",
                 score2, board_out2, lines_cleared2, exp_s);
      end
      total++;
      if (level2 !== 4'(m_level(exp_t))) begin
        bad++;
        $display("FAIL sat_level: got %0d expected %0d", level2, m_level(exp_t));
      end
    end
    @(negedge clka);
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_restart_mid();
    test_single_row();
    test_two_rows();
    test_touched_hold();
    test_retrigger();
    test_game_over();
    test_multi();
    test_score_sat();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: %0d entries remain expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_clear.md
Name: line_clear

Overview:
Downstream stage of the Tetris datapath. It consumes the 32-bit board the datapath produces once a piece lands (touched), and removes every completely filled row. Rows above a cleared row drop down by one. It updates the score and returns the compacted board for the datapath to reload. It is a multi-cycle row scanner (one row per cycle) with a busy/done handshake.

Parameters:
ROWS, 8, board rows; row r = board[4r+3:4r], row 0 = bottom, row ROWS-1 = top
COLS, 4, cells per row; ROWS*COLS must equal 32
SCORE_W, 16, score register width

Ports:
clka  in  1  single system clock, rising-edge
restart  in  1  asynchronous, active-high reset
touched  in  1  datapath piece-landed flag; starts a pass when sampled high in IDLE
board_in  in  32  board from datapath, sampled on the start edge only
board_out  out  32  compacted board, registered
done  out  1  one-cycle pulse: board_out/score/lines_cleared valid
busy  out  1  high in any state except IDLE
lines_cleared  out  4  full rows removed in the last pass
score  out  SCORE_W  accumulated score, saturating
game_over  out  1  sticky; top row occupied after a pass
level  out  4  see Optional Feature

Behaviour:
- Reset is asynchronous and active-high on restart, with one clock clka. On reset, all outputs and registers are 0 and the FSM is in IDLE. A restart in mid-pass aborts immediately; the partial board is discarded.
- FSM states are IDLE, SCAN, SHIFT, DONE.
- IDLE:
  - If touched=1 at an edge (E0): work <= board_in, idx <= 0, cnt <= 0, go to SCAN.
  - touched is level-sensitive: if it is still high on return to IDLE, a new pass starts.
- SCAN: examine row work[idx].
  - Row == all ones: go to SHIFT.
  - Otherwise, if idx == ROWS-1: go to DONE.
  - Otherwise: idx++.
- SHIFT:
  - For r = idx..ROWS-2, row r <= row r+1; row ROWS-1 <= 0.
  - cnt++ (saturate at 15), return to SCAN with the same idx so that row is rechecked.
- DONE (exactly 1 cycle):
  - board_out <= work, lines_cleared <= cnt and score <= sat(score + pts(cnt)) are all written on the edge entering DONE.
  - done = 1 while in DONE. Next state is IDLE.
- Latency: with F full rows, DONE is entered at edge E0 + ROWS + 2F (8 cycles for F=0).
- pts(): 0→0, 1→1, 2→3, 3→5, ≥4→8.
- Score addition is SCORE_W-bit and saturates at all ones; it never wraps.
- game_over is set on entering DONE if the top row of work is non-zero. It stays set until restart. Passes still run while it is set.
- touched while busy is ignored; there is no queueing.
- board_out holds its value between passes.
- done and busy are never asserted in IDLE. busy is high in DONE.

Optional Feature:
Macro: LINE_CLEAR_LEVEL_EN.
- Defined:
  - An 8-bit total-lines counter accumulates cnt on each DONE, saturating at 255.
  - level = min(total_lines/4, 15), registered with DONE.
  - restart clears both the counter and level.
- Undefined: level is tied to 4'd0 and there is no counter logic.

Decomposition:
- Shared package tetris_pkg holds:
  - the state enum (IDLE/SCAN/SHIFT/DONE)
  - ROWS/COLS defaults, the 32-bit board width constant
  - the pts() lookup function
  - the FULL_ROW constant (4'hF)
- One sub-module, row_shifter: combinational. Inputs are the board and idx; output is the board with row idx removed and zero filled at the top. It is used in SHIFT.

Test Plan:
1. Assert restart mid-run, then release it → board_out=0, score=0, lines_cleared=0, game_over=0, busy=0, done=0.
2. board_in=0x0000_000F, touched pulse → done at E0+10, board_out=0x0000_0000, lines_cleared=1, score=1, busy high E0..done.
3. board_in=0x0000_2FF1 → done at E0+12, board_out=0x0000_0021, lines_cleared=2, score += 3.
4. board_in=0x0000_0000 with touched held high for 3 cycles during busy → exactly one pass, done at E0+8, score unchanged. If touched is still high in IDLE, a second pass starts.
5. board_in=0x1000_0000 → done at E0+8, game_over=1. A following pass on 0x0000_0000 leaves game_over=1 until restart.
6. Preload score to 0xFFFC (via repeated passes, or force) then clear 4 rows (board 0x0000_FFFF) → score=0xFFFF. With LINE_CLEAR_LEVEL_EN, level=1 after the 4-line pass; without it, level=0.
